// File: rtl/encoder_16_4_pkg.sv
// Shared constants and types for the 16-to-4 priority encoder.
//   ENC_IN_W / ENC_OUT_W : width of the top-level request and code buses
//   SUB_IN_W / SUB_OUT_W : width of the 8-to-3 building block
//   L_RST                : value of the code output while in reset
package encoder_16_4_pkg;

  localparam int unsigned ENC_IN_W  = 16;
  localparam int unsigned ENC_OUT_W = 4;
  localparam int unsigned SUB_IN_W  = 8;
  localparam int unsigned SUB_OUT_W = 3;

  localparam logic [ENC_OUT_W-1:0] L_RST = '0;

  // Registered output bundle of the top-level encoder.
  typedef struct packed {
    logic [ENC_OUT_W-1:0] l;
    logic                 gs;
    logic                 eo;
  } enc_out_t;

  localparam enc_out_t ENC_OUT_RST = '{l: L_RST, gs: 1'b0, eo: 1'b0};

endpackage

// File: rtl/encoder_16_4_prio_enc8_3.sv
// prio_enc8_3: purely combinational 8-to-3 priority encoder, bit 7 highest.
// Ports:
//   ei  in   enable in; 0 forces l=0, gs=0, eo=0
//   a   in   request lines, active-high
//   l   out  index of the most significant set bit of a (0 when none/disabled)
//   gs  out  enabled and at least one request set
//   eo  out  enabled and no request set (drives ei of the next-lower stage)
module prio_enc8_3
  import encoder_16_4_pkg::*;
(
  input  logic                 ei,
  input  logic [SUB_IN_W-1:0]  a,
  output logic [SUB_OUT_W-1:0] l,
  output logic                 gs,
  output logic                 eo
);

  always_comb begin
    l  = '0;
    gs = 1'b0;
    eo = 1'b0;
    if (ei) begin
      gs = |a;
      eo = ~(|a);
      // Ascending scan: the last hit, i.e. the highest set bit, wins.
      for (int unsigned i = 0; i < SUB_IN_W; i++) begin
        if (a[i]) begin
          l = SUB_OUT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/encoder_16_4.sv
// encoder_16_4: registered 16-to-4 priority encoder, bit 15 highest.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset; clears L, GS, EO
//   EI     in   enable in; 0 disables encoding
//   A      in   16 request lines, active-high
//   L      out  registered index of the highest asserted A bit
//   GS     out  registered: enabled and some A bit set
//   EO     out  registered: enabled and no A bit set (cascade enable-out)
module encoder_16_4
  import encoder_16_4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 EI,
  input  logic [ENC_IN_W-1:0]  A,
  output logic [ENC_OUT_W-1:0] L,
  output logic                 GS,
  output logic                 EO
);

  logic [SUB_OUT_W-1:0] hi_l, lo_l;
  logic                 hi_gs, lo_gs;
  logic                 hi_eo, lo_eo;

  enc_out_t out_d, out_q;

  prio_enc8_3 u_hi (
    .ei (EI),
    .a  (A[ENC_IN_W-1:SUB_IN_W]),
    .l  (hi_l),
    .gs (hi_gs),
    .eo (hi_eo)
  );

  // Low half is only enabled when the high half is enabled and idle, so its
  // l is zero whenever the high half has a hit; OR-ing the two l buses is safe.
  prio_enc8_3 u_lo (
    .ei (hi_eo),
    .a  (A[SUB_IN_W-1:0]),
    .l  (lo_l),
    .gs (lo_gs),
    .eo (lo_eo)
  );

  always_comb begin
    out_d    = ENC_OUT_RST;
    out_d.l  = {hi_gs, hi_l | lo_l};
    out_d.gs = hi_gs | lo_gs;
    out_d.eo = lo_eo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= ENC_OUT_RST;
    end else begin
      out_q <= out_d;
    end
  end

  assign L  = out_q.l;
  assign GS = out_q.gs;
  assign EO = out_q.eo;

endmodule

// File: tb/tb_encoder_16_4.sv
module tb_encoder_16_4;

  logic        clk;
  logic        rst_n;
  logic        EI;
  logic [15:0] A;
  logic [3:0]  L;
  logic        GS;
  logic        EO;

  int unsigned n_checks;
  int unsigned n_errors;

  encoder_16_4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .EI    (EI),
    .A     (A),
    .L     (L),
    .GS    (GS),
    .EO    (EO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares the packed {L,GS,EO} observation against the expected value.
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got L=%0d GS=%b EO=%b, expected L=%0d GS=%b EO=%b",
               tag, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {L, GS, EO};
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [3:0]  l;
  } prio_vec_t;

  prio_vec_t prio_tab[4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    prio_tab[0] = '{a: 16'h8001, l: 4'd15};
    prio_tab[1] = '{a: 16'h00FF, l: 4'd7};
    prio_tab[2] = '{a: 16'h0100, l: 4'd8};
    prio_tab[3] = '{a: 16'h7F80, l: 4'd14};

    // Reset asserted asynchronously, before any clock edge.
    rst_n = 1'b1;
    EI    = 1'b1;
    A     = 16'hFFFF;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", obs(), {4'd0, 1'b0, 1'b0});
    step();
    chk("reset_held1", obs(), {4'd0, 1'b0, 1'b0});
    step();
    chk("reset_held2", obs(), {4'd0, 1'b0, 1'b0});

    // First edge after release loads from current inputs.
    rst_n = 1'b1;
    step();
    chk("post_reset_load", obs(), {4'd15, 1'b1, 1'b0});

    // Disabled.
    EI = 1'b0;
    A  = 16'h0000;
    step();
    chk("disabled_zero", obs(), {4'd0, 1'b0, 1'b0});
    A = 16'hFFFF;
    step();
    chk("disabled_ones", obs(), {4'd0, 1'b0, 1'b0});

    // Enabled idle.
    EI = 1'b1;
    A  = 16'h0000;
    step();
    chk("enabled_idle", obs(), {4'd0, 1'b0, 1'b1});

    // Walking one.
    for (int i = 0; i < 16; i++) begin
      A = 16'h0001 << i;
      step();
      chk($sformatf("walk_%0d", i), obs(), {4'(i), 1'b1, 1'b0});
    end

    // Priority resolution.
    for (int i = 0; i < 4; i++) begin
      A = prio_tab[i].a;
      step();
      chk($sformatf("prio_%h", prio_tab[i].a), obs(), {prio_tab[i].l, 1'b1, 1'b0});
    end

    // Hold with stable inputs (A = 16'h7F80 from the table).
    step();
    chk("hold_stable", obs(), {4'd14, 1'b1, 1'b0});

    // Latency: change between edges, outputs must not move until the edge.
    A = 16'h0004;
    #3 chk("latency_before", obs(), {4'd14, 1'b1, 1'b0});
    step();
    chk("latency_after", obs(), {4'd2, 1'b1, 1'b0});

    // Mid-cycle reset overrides a pending update.
    A = 16'h0010;
    #2 rst_n = 1'b0;
    #1 chk("midcycle_reset", obs(), {4'd0, 1'b0, 1'b0});
    step();
    chk("midcycle_reset_edge", obs(), {4'd0, 1'b0, 1'b0});
    rst_n = 1'b1;
    step();
    chk("reset_release_load", obs(), {4'd4, 1'b1, 1'b0});

    // Disable after an active value clears outputs.
    EI = 1'b0;
    step();
    chk("disable_clears", obs(), {4'd0, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encoder_16_4.md
ENCODER_16_4 -- requirements
Module: encoder_16_4

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 16 inputs / 4 code bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 EI  input  1  enable in, active-high; 0 disables encoding.
REQ-005 A  input  16  request lines, active-high; bit 15 has highest priority.
REQ-006 L  output  4  registered binary index of the highest-priority asserted A bit.
REQ-007 GS  output  1  registered group-select; 1 = enabled and at least one A bit is 1.
REQ-008 EO  output  1  registered enable-out for cascading; 1 = enabled and all A bits are 0.

Function
REQ-009 Each cycle the block SHALL compute the next outputs combinationally from EI and A, then register them; latency is exactly 1 clk from input change to output change.
REQ-010 With EI=1 and A!=0, next L SHALL be the index of the most significant 1 in A, next GS=1, next EO=0.
REQ-011 With EI=1 and A=0, next L SHALL be 0, next GS=0, next EO=1.
REQ-012 With EI=0, next L SHALL be 0, next GS=0, next EO=0, regardless of A.
REQ-013 Multiple asserted bits SHALL resolve purely by priority (e.g. A=16'h8001 -> L=15); lower bits are ignored.
REQ-014 GS and EO SHALL never both be 1; L=0 with GS=0 SHALL be distinguishable from a real index 0 only through GS.
REQ-015 Outputs SHALL hold their value while inputs are stable; no other state exists.
REQ-016 The block SHALL be fully synchronous apart from the asynchronous reset; no combinational path from inputs to outputs.

Reset
REQ-017 While rst_n=0, L SHALL be 4'd0, GS=0, EO=0, asserted asynchronously without waiting for clk.
REQ-018 After rst_n deasserts, the first rising clk edge SHALL load outputs per REQ-010..REQ-012 from the current EI/A.
REQ-019 Reset asserted mid-operation SHALL clear outputs immediately, overriding any pending update.

Structure
REQ-020 The 16-4 function SHALL be built from two instances of a combinational sub-module prio_enc8_3 (inputs ei, a[7:0]; outputs l[2:0], gs, eo), cascaded: high-half eo drives low-half ei; L[3] = high-half gs; L[2:0] = OR of both halves' l; GS = OR of both gs; EO = low-half eo.
REQ-021 prio_enc8_3 SHALL follow REQ-010..REQ-012 semantics at 8/3 width and contain no registers.
REQ-022 A shared package SHALL hold constants ENC_IN_W=16, ENC_OUT_W=4, SUB_IN_W=8, SUB_OUT_W=3 and the reset value of L.
REQ-023 The output register stage SHALL reside in encoder_16_4 only.

Verification
REQ-024 Reset: rst_n=0, EI=1, A=16'hFFFF -> L=0, GS=0, EO=0 immediately and while reset held.
REQ-025 Disabled: EI=0, A=16'h0000 then 16'hFFFF -> L=0, GS=0, EO=0 after each clk.
REQ-026 Enabled idle: EI=1, A=16'h0000 -> after 1 clk L=0, GS=0, EO=1.
REQ-027 Walking one: EI=1, A=16'h0001 shifted left one bit per clk through 16'h8000 -> L=0,1,...,15 each one clk later, GS=1, EO=0 throughout.
REQ-028 Priority: EI=1, A=16'h8001 -> L=15; A=16'h00FF -> L=7; A=16'h0100 -> L=8 (half boundary); GS=1, EO=0.
REQ-029 Latency/async reset: change A on one edge, check outputs unchanged before next edge and updated after; assert rst_n=0 between edges -> outputs clear before next edge.
